// File: rtl/vga_scan_engine_if.sv
// Pixel interface between the scan engine (reader) and the compositor.
// The scan engine publishes the address and read strobe; the compositor
// answers with the 12-bit colour word for that address.
interface vga_scan_engine_if;
    logic [11:0] d_in;      // {R[11:8], G[7:4], B[3:0]} from the compositor
    logic [8:0]  row_addr;  // current visible line
    logic [9:0]  col_addr;  // current visible column
    logic        rdn;       // active-low read strobe, 0 while address is visible

    // Scan engine side
    modport master (
        input  d_in,
        output row_addr,
        output col_addr,
        output rdn
    );

    // Compositor side
    modport slave (
        output d_in,
        input  row_addr,
        input  col_addr,
        input  rdn
    );
endinterface

// File: rtl/vga_scan_engine.sv
// VGA scan-out engine: pixel-rate divider, h/v raster counters, an address
// stage presented to the compositor, and an output stage that registers
// sync and colour together so they leave the chip pixel-aligned.
module vga_scan_engine #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic               clk,
    input  logic               rstn,
    vga_scan_engine_if.master  pix,
    output logic               pix_tick,
    output logic               frame_start,
    output logic               hs,
    output logic               vs,
    output logic [3:0]         r,
    output logic [3:0]         g,
    output logic [3:0]         b
);

    // Raster boundaries, all derived from the timing parameters.
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    // Divider terminal value, and the value one clk before it: pix_tick is
    // registered, so it is scheduled on the clk preceding the terminal count.
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [3:0] DIV_PRE  = 4'(CLK_DIV - 2);

    logic [3:0] div_reg;
    logic       pix_tick_reg;
    logic       frame_start_reg;
    logic [9:0] h_cnt_reg;
    logic [9:0] v_cnt_reg;
    logic [9:0] col_addr_reg;
    logic [8:0] row_addr_reg;
    logic       rdn_reg;
    logic       hs_reg;
    logic       vs_reg;
    logic [3:0] r_reg;
    logic [3:0] g_reg;
    logic [3:0] b_reg;

    logic visible;
    logic h_last;
    logic v_last;
    logic in_hsync;
    logic in_vsync;
    logic tick_next;

    assign visible   = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
    assign h_last    = (h_cnt_reg == H_LAST);
    assign v_last    = (v_cnt_reg == V_LAST);
    assign in_hsync  = (h_cnt_reg >= HS_FIRST) && (h_cnt_reg <= HS_LAST);
    assign in_vsync  = (v_cnt_reg >= VS_FIRST) && (v_cnt_reg <= VS_LAST);
    assign tick_next = (div_reg == DIV_PRE);

    // Pixel-rate divider; pix_tick is high exactly while div_reg == DIV_LAST,
    // and frame_start marks the tick on which the raster wraps to (0,0).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_reg         <= '0;
            pix_tick_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            div_reg         <= (div_reg == DIV_LAST) ? 4'd0 : div_reg + 4'd1;
            pix_tick_reg    <= tick_next;
            frame_start_reg <= tick_next && h_last && v_last;
        end
    end

    // Raster counters advance once per pixel period.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (pix_tick_reg) begin
            if (h_last) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= v_last ? 10'd0 : v_cnt_reg + 10'd1;
            end else begin
                h_cnt_reg <= h_cnt_reg + 10'd1;
            end
        end
    end

    // Address stage follows the counters by one clk, giving the compositor
    // the remaining CLK_DIV-1 clks of the pixel period to return data.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            col_addr_reg <= '0;
            row_addr_reg <= '0;
            rdn_reg      <= 1'b1;
        end else begin
            col_addr_reg <= visible ? h_cnt_reg : 10'd0;
            row_addr_reg <= visible ? v_cnt_reg[8:0] : 9'd0;
            rdn_reg      <= ~visible;
        end
    end

    // Output stage: on the tick that ends a pixel period, the counters still
    // describe that pixel, so sync and colour are derived from the same state
    // and leave together. Blanked pixels force colour to zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hs_reg <= 1'b1;
            vs_reg <= 1'b1;
            r_reg  <= '0;
            g_reg  <= '0;
            b_reg  <= '0;
        end else if (pix_tick_reg) begin
            hs_reg <= ~in_hsync;
            vs_reg <= ~in_vsync;
            r_reg  <= visible ? pix.d_in[11:8] : 4'd0;
            g_reg  <= visible ? pix.d_in[7:4]  : 4'd0;
            b_reg  <= visible ? pix.d_in[3:0]  : 4'd0;
        end
    end

    assign pix.col_addr = col_addr_reg;
    assign pix.row_addr = row_addr_reg;
    assign pix.rdn      = rdn_reg;
    assign pix_tick     = pix_tick_reg;
    assign frame_start  = frame_start_reg;
    assign hs           = hs_reg;
    assign vs           = vs_reg;
    assign r            = r_reg;
    assign g            = g_reg;
    assign b            = b_reg;

endmodule
